// File: rtl/dmem_responder_if.sv
// Request/response bundle between a pipeline memory stage (master) and the data-memory responder (slave).
// Requests use valid/ready; responses are a single-cycle resp_valid pulse with no backpressure.
interface dmem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states, then the array access and a 1-cycle resp_valid.
// Latency: resp_valid seen WAIT_CYCLES+2 edges after acceptance; req_ready only in IDLE, requests while busy are dropped.
// Optional DMEM_ERR_EN: flag out-of-range addresses on resp_err (out-of-range writes are dropped, reads return 0 either way).
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             busy
);
    localparam int               IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign accept   = bus.req_valid && (state == S_IDLE);
    assign in_range = {1'b0, addr_q} < DEPTH_LIM;
    assign idx      = addr_q[IDX_W-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cnt_nx = WAIT_LOAD;
                    if (WAIT_CYCLES > 0) state_nx = S_WAIT;
                    else                 state_nx = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nx = S_ACCESS;
                else             cnt_nx   = cnt - 4'd1;
            end
            S_ACCESS: state_nx = S_RESP;
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                rw_q    <= bus.req_rw;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == S_ACCESS && rw_q) begin
                rdata_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    // The array itself is never reset; an abort simply leaves the FSM out of ACCESS.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && !rw_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign busy           = (state != S_IDLE);

`ifdef DMEM_ERR_EN
    assign bus.resp_err = (state == S_RESP) && !in_range;
`else
    assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 (2 wait states, 4096 words) and instance 1 (no wait states, 1024 words),
// each compared every cycle against a transaction-phase model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int NI    = 2;
    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int D0    = 4096;
    localparam int D1    = 1024;
    localparam int BOUND = 64;
`ifdef DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [NI];
    logic        req_rw    [NI];
    logic [11:0] req_addr  [NI];
    logic [15:0] req_wdata [NI];
    logic        req_ready [NI];
    logic        resp_valid[NI];
    logic [15:0] resp_rdata[NI];
    logic        resp_err  [NI];
    logic        busy      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder_if #(.DATA_W(16), .ADDR_W(12)) bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.req_rw    = req_rw[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign req_ready[g]  = bus.req_ready;
        assign resp_valid[g] = bus.resp_valid;
        assign resp_rdata[g] = bus.resp_rdata;
        assign resp_err[g]   = bus.resp_err;

        dmem_responder #(
            .DATA_W(16), .ADDR_W(12),
            .MEM_DEPTH((g == 0) ? D0 : D1),
            .WAIT_CYCLES((g == 0) ? W0 : W1)
        ) dut (
            .clk(clk), .reset(reset), .bus(bus), .busy(busy[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: p = cycles since acceptance (0 = idle); wait states, then one access cycle, then the response cycle.
    int          p     [NI];
    logic        m_rw  [NI];
    logic [11:0] m_addr[NI];
    logic [15:0] m_wd  [NI];
    logic [15:0] m_rd  [NI];
    bit          m_rk  [NI];
    bit          m_oor [NI];
    logic [15:0] mem_m [NI][4096];
    bit          kn_m  [NI][4096];
    int          npulse[NI];

    function automatic int wc(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out after %0d cycles", name, BOUND);
    endtask

    task automatic model_step(input int i);
        int w;
        bit inr;
        w = wc(i);
        if (!reset) begin
            p[i] = 0; m_rd[i] = '0; m_rk[i] = 1'b1;
        end else if (p[i] == 0) begin
            if (req_valid[i]) begin
                m_rw[i] = req_rw[i]; m_addr[i] = req_addr[i]; m_wd[i] = req_wdata[i];
                p[i] = 1;
            end
        end else if (p[i] == w + 1) begin
            inr = int'(m_addr[i]) < dep(i);
            m_oor[i] = !inr;
            if (m_rw[i]) begin
                m_rd[i] = inr ? mem_m[i][m_addr[i]] : 16'h0000;
                m_rk[i] = inr ? kn_m[i][m_addr[i]] : 1'b1;
            end else if (inr) begin
                mem_m[i][m_addr[i]] = m_wd[i];
                kn_m[i][m_addr[i]]  = 1'b1;
            end
            p[i] = w + 2;
        end else if (p[i] == w + 2) begin
            p[i] = 0;
        end else begin
            p[i]++;
        end
    endtask

    task automatic compare(input int i);
        bit rv;
        rv = (p[i] == wc(i) + 2);
        chk($sformatf("u%0d.req_ready", i), req_ready[i], p[i] == 0);
        chk($sformatf("u%0d.busy", i), busy[i], p[i] != 0);
        chk($sformatf("u%0d.resp_valid", i), resp_valid[i], rv);
        chk($sformatf("u%0d.resp_err", i), resp_err[i], rv && ERR && m_oor[i]);
        if (m_rk[i]) chk($sformatf("u%0d.resp_rdata", i), resp_rdata[i], m_rd[i]);
        if (resp_valid[i] === 1'b1) npulse[i]++;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            p[i] = 0; m_rd[i] = '0; m_rk[i] = 1'b1; m_oor[i] = 1'b0; npulse[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) model_step(i);
            @(negedge clk);
            for (int i = 0; i < NI; i++) compare(i);
        end
    end

    // Called and returns at negedge+1; rdata/err are sampled in the response cycle.
    task automatic xact(input int i, input bit rw, input logic [11:0] a, input logic [15:0] d,
                        input bit hold, input bit nrw, input logic [11:0] na, input logic [15:0] nd,
                        output logic [15:0] rdata, output logic err, output int lat, output int acc);
        int n;
        n = 0;
        req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a; req_wdata[i] = d;
        while (req_ready[i] !== 1'b1 && n < BOUND) begin
            @(negedge clk); #1; n++;
        end
        if (n >= BOUND) timeout($sformatf("u%0d.accept", i));
        @(negedge clk); #1;
        acc = cyc;
        if (hold) begin
            req_rw[i] = nrw; req_addr[i] = na; req_wdata[i] = nd;
        end else begin
            req_valid[i] = 1'b0;
            req_rw[i] = 1'($urandom); req_addr[i] = 12'($urandom); req_wdata[i] = 16'($urandom);
        end
        lat = 1;
        while (resp_valid[i] !== 1'b1 && lat < BOUND) begin
            @(negedge clk); #1; lat++;
        end
        if (lat >= BOUND) timeout($sformatf("u%0d.resp", i));
        rdata = resp_rdata[i];
        err   = resp_err[i];
    endtask

    task automatic rand_run(input int i, input int count);
        logic [15:0] rd;
        logic        er;
        int          lat, acc;
        logic [11:0] base, a;
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
            base = ($urandom_range(0, 1) == 0) ? 12'h000 : ((i == 0) ? 12'hFF0 : 12'h3F8);
            a    = base + 12'($urandom_range(0, 15));
            xact(i, 1'($urandom), a, 16'($urandom), 1'($urandom), 1'($urandom),
                 base + 12'($urandom_range(0, 15)), 16'($urandom), rd, er, lat, acc);
            chk($sformatf("u%0d.rand_latency", i), lat, wc(i) + 2);
        end
        @(negedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat, a0, a1, np, n;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.rst_ready", i), req_ready[i], 1'b1);
            chk($sformatf("u%0d.rst_busy", i), busy[i], 1'b0);
            chk($sformatf("u%0d.rst_resp_valid", i), resp_valid[i], 1'b0);
            chk($sformatf("u%0d.rst_rdata", i), resp_rdata[i], 16'h0000);
        end

        // Two wait states: write then read back, response 4 edges after acceptance.
        xact(0, 1'b0, 12'h005, 16'hBEEF, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u0.wr_latency", lat, 4);
        xact(0, 1'b1, 12'h005, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u0.rd_latency", lat, 4);
        chk("u0.rd_005", rd, 16'hBEEF);

        // Request held high across a busy transaction is taken only after the response cycle.
        np = npulse[0];
        xact(0, 1'b0, 12'h006, 16'h1234, 1'b1, 1'b1, 12'h006, 16'h0000, rd, er, lat, a0);
        xact(0, 1'b1, 12'h006, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a1);
        chk("u0.busy_ignore_gap", a1 - a0, 5);
        chk("u0.busy_ignore_data", rd, 16'h1234);
        chk("u0.busy_ignore_pulses", npulse[0] - np, 2);

        xact(0, 1'b0, 12'hFFF, 16'h8000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        xact(0, 1'b1, 12'hFFF, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u0.rd_fff", rd, 16'h8000);
        chk("u0.err_fff", er, 1'b0);

        // Zero wait states: back-to-back reads three cycles apart.
        xact(1, 1'b0, 12'h000, 16'h0001, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        xact(1, 1'b0, 12'h3FF, 16'h8000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        xact(1, 1'b1, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h3FF, 16'h0000, rd, er, lat, a0);
        chk("u1.rd_latency", lat, 2);
        chk("u1.rd_000", rd, 16'h0001);
        xact(1, 1'b1, 12'h3FF, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a1);
        chk("u1.b2b_gap", a1 - a0, 3);
        chk("u1.rd_3ff", rd, 16'h8000);
        chk("u1.err_3ff", er, 1'b0);

        // Out of range on the 1024-word instance.
        xact(1, 1'b0, 12'h400, 16'h5555, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u1.err_wr_400", er, ERR);
        xact(1, 1'b1, 12'h400, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u1.err_rd_400", er, ERR);
        chk("u1.rd_400", rd, 16'h0000);

        // Reset in the wait state aborts the write and its response.
        xact(0, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 12'h010; req_wdata[0] = 16'hAAAA;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < BOUND) begin
            @(negedge clk); #1; n++;
        end
        if (n >= BOUND) timeout("u0.abort_accept");
        @(negedge clk); #1;
        req_valid[0] = 1'b0;
        chk("u0.abort_busy", busy[0], 1'b1);
        np = npulse[0];
        reset = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        reset = 1'b1;
        repeat (6) begin @(negedge clk); #1; end
        chk("u0.abort_no_pulse", npulse[0] - np, 0);
        xact(0, 1'b1, 12'h010, 16'h0000, 1'b0, 1'b0, '0, '0, rd, er, lat, a0);
        chk("u0.abort_rd_010", rd, 16'h0000);

        fork
            rand_run(0, 80);
            rand_run(1, 80);
        join
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
